cam_lru: RTL

- Parametrised successor to the team's fixed 8x8 CAM.
- Fully associative tag/data store with configurable tag width, data width and depth.
- Registered lookup and automatic slot allocation on write: hit-overwrite, else first invalid slot, else true-LRU victim.
- Sits beside a small TLB/cache front end as its lookup store.

---
 rtl/cam_pkg.sv | 22 ++
 rtl/cam_lru_if.sv | 53 +++++
 rtl/cam_lru_age.sv | 76 +++++++
 rtl/cam_lru.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the cam_lru lookup store: default geometry,
// the age type for that geometry, and the statistics counter width.
// The optional statistics counters are enabled by the CAM_STATS_EN macro.
package cam_pkg;

  localparam int CAM_BITS      = 8;
  localparam int CAM_TAG_SZ    = 8;
  localparam int CAM_WORDS     = 8;
  localparam int CAM_ADDR_LEFT = $clog2(CAM_WORDS) - 1;

  // Width of the saturating hit/miss/evict counters.
  localparam int STAT_W = 16;

  // Age (recency rank) of one entry in the default geometry; 0 = MRU.
  typedef logic [CAM_ADDR_LEFT:0] age_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/cam_lru_if.sv
// Lookup/write bus of the cam_lru store.
// With CAM_STATS_EN defined the bus also carries hit_cnt, miss_cnt and
// evict_cnt from the store.
//
// Handshake: there is no ready. read and write_ (active low) are
// single-cycle strobes sampled on every rising clock edge and always
// accepted; a lookup result appears on data/found_it/hit_idx after the
// edge that sampled read and holds until the next read. full and w_idx
// are combinational views of the current state and write request.
interface cam_lru_if import cam_pkg::*; #(
  parameter int BITS   = CAM_BITS,
  parameter int TAG_SZ = CAM_TAG_SZ,
  parameter int WORDS  = CAM_WORDS
);
  localparam int ADDR_LEFT = $clog2(WORDS) - 1;

  logic                read;
  logic [TAG_SZ-1:0]   check_tag;
  logic [BITS-1:0]     data;
  logic                found_it;
  logic [ADDR_LEFT:0]  hit_idx;
  logic                write_;
  logic [TAG_SZ-1:0]   new_tag;
  logic [BITS-1:0]     wdata;
  logic                new_valid;
  logic                flush;
  logic                full;
  logic [ADDR_LEFT:0]  w_idx;
`ifdef CAM_STATS_EN
  logic [STAT_W-1:0]   hit_cnt;
  logic [STAT_W-1:0]   miss_cnt;
  logic [STAT_W-1:0]   evict_cnt;
`endif

  // Requester side (front end / bench).
  modport master (
    output read, check_tag, write_, new_tag, wdata, new_valid, flush,
    input  data, found_it, hit_idx, full, w_idx
`ifdef CAM_STATS_EN
    , input hit_cnt, miss_cnt, evict_cnt
`endif
  );

  // Store side.
  modport slave (
    input  read, check_tag, write_, new_tag, wdata, new_valid, flush,
    output data, found_it, hit_idx, full, w_idx
`ifdef CAM_STATS_EN
    , output hit_cnt, miss_cnt, evict_cnt
`endif
  );

endinterface

// File: rtl/cam_lru_age.sv
// True-LRU age registers for cam_lru. Each entry holds its recency rank
// (0 = most recent, WORDS-1 = least recent); the ranks always form a
// permutation of 0..WORDS-1. Two accesses may land on the same edge: the
// read-hit access is applied first and the write access last, so a
// written entry always ends as MRU.
module cam_lru_age import cam_pkg::*; #(
  parameter int WORDS = CAM_WORDS
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       rd_en,
  input  logic [$clog2(WORDS)-1:0]   rd_idx,
  input  logic                       wr_en,
  input  logic [$clog2(WORDS)-1:0]   wr_idx,
  output logic [$clog2(WORDS)-1:0]   lru_idx
);

  localparam int ADDR_LEFT = $clog2(WORDS) - 1;

  typedef logic [ADDR_LEFT:0]             idx_t;
  typedef logic [WORDS-1:0][ADDR_LEFT:0]  age_vec_t;

  age_vec_t age_q;
  age_vec_t age_mid;
  age_vec_t age_nxt;

  // Make entry k the MRU: everything more recent than k ages by one.
  function automatic age_vec_t touch(input age_vec_t a, input idx_t k);
    age_vec_t r;
    for (int j = 0; j < WORDS; j++) begin
      if (idx_t'(j) == k) begin
        r[j] = '0;
      end else if (a[j] < a[k]) begin
        r[j] = a[j] + 1'b1;
      end else begin
        r[j] = a[j];
      end
    end
    return r;
  endfunction

  // Next ages: read-hit access first, write access second.
  always_comb begin
    age_mid = age_q;
    age_nxt = age_q;
    if (rd_en) begin
      age_mid = touch(age_q, rd_idx);
    end
    age_nxt = age_mid;
    if (wr_en) begin
      age_nxt = touch(age_mid, wr_idx);
    end
  end

  // Age registers; reset ranks entry i as age i so the last entry is LRU.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int i = 0; i < WORDS; i++) begin
        age_q[i] <= idx_t'(i);
      end
    end else begin
      age_q <= age_nxt;
    end
  end

  // The victim is the one entry whose rank is WORDS-1.
  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (age_q[i] == idx_t'(WORDS - 1)) begin
        lru_idx = idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/cam_lru.sv
// cam_lru: fully associative tag/data lookup store with registered lookup
// and automatic slot allocation on write (hit-overwrite, else lowest free
// entry, else the true-LRU victim). Optional statistics counters
// (hit_cnt, miss_cnt, evict_cnt) are built when CAM_STATS_EN is defined.
// rst_ is asynchronous and active-high.
module cam_lru import cam_pkg::*; #(
  parameter int BITS   = CAM_BITS,
  parameter int TAG_SZ = CAM_TAG_SZ,
  parameter int WORDS  = CAM_WORDS
) (
  input  logic      clk,
  input  logic      rst_,
  cam_lru_if.slave  bus
);

  localparam int ADDR_LEFT = $clog2(WORDS) - 1;

  typedef logic [ADDR_LEFT:0] idx_t;

  // Entry storage.
  logic [WORDS-1:0]   val_mem;
  logic [TAG_SZ-1:0]  tag_mem  [WORDS];
  logic [BITS-1:0]    data_mem [WORDS];

  // Lookup result registers.
  logic [BITS-1:0]    data_q;
  logic               found_q;
  idx_t               hit_idx_q;

  // Match / allocation signals.
  logic               rd_hit;
  idx_t               rd_idx;
  logic               wr_hit;
  idx_t               wr_hit_idx;
  logic               free_any;
  idx_t               free_idx;
  idx_t               lru_idx;
  idx_t               w_sel;
  logic               wr_go;
  logic               install;
  logic               inval;

  // Lookup match; descending scan so the lowest matching index wins.
  always_comb begin
    rd_hit = 1'b0;
    rd_idx = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (val_mem[i] && tag_mem[i] == bus.check_tag) begin
        rd_hit = 1'b1;
        rd_idx = idx_t'(i);
      end
    end
  end

  // Write-side match on new_tag and lowest free entry, same priority.
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    free_any   = 1'b0;
    free_idx   = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (val_mem[i] && tag_mem[i] == bus.new_tag) begin
        wr_hit     = 1'b1;
        wr_hit_idx = idx_t'(i);
      end
      if (!val_mem[i]) begin
        free_any = 1'b1;
        free_idx = idx_t'(i);
      end
    end
  end

  // Slot choice: existing tag, else lowest free, else LRU victim.
  assign w_sel = wr_hit ? wr_hit_idx : (free_any ? free_idx : lru_idx);

  // flush wins over a coincident write.
  assign wr_go   = !bus.write_ && !bus.flush;
  assign install = wr_go && bus.new_valid;
  assign inval   = wr_go && !bus.new_valid && wr_hit;

  cam_lru_age #(
    .WORDS (WORDS)
  ) u_age (
    .clk     (clk),
    .rst_    (rst_),
    .rd_en   (bus.read && rd_hit),
    .rd_idx  (rd_idx),
    .wr_en   (install),
    .wr_idx  (w_sel),
    .lru_idx (lru_idx)
  );

  // Entry storage: flush, install/overwrite, or invalidate.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      val_mem <= '0;
      for (int i = 0; i < WORDS; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else if (bus.flush) begin
      val_mem <= '0;
    end else if (install) begin
      val_mem[w_sel]  <= 1'b1;
      tag_mem[w_sel]  <= bus.new_tag;
      data_mem[w_sel] <= bus.wdata;
    end else if (inval) begin
      val_mem[wr_hit_idx] <= 1'b0;
    end
  end

  // Registered lookup from pre-edge contents; holds between reads.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      data_q    <= '0;
      found_q   <= 1'b0;
      hit_idx_q <= '0;
    end else if (bus.read) begin
      data_q    <= rd_hit ? data_mem[rd_idx] : '0;
      found_q   <= rd_hit;
      hit_idx_q <= rd_hit ? rd_idx : '0;
    end
  end

  assign bus.data     = data_q;
  assign bus.found_it = found_q;
  assign bus.hit_idx  = hit_idx_q;
  assign bus.full     = &val_mem;
  assign bus.w_idx    = w_sel;

`ifdef CAM_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q;
  logic [STAT_W-1:0] miss_cnt_q;
  logic [STAT_W-1:0] evict_cnt_q;

  // Hit/miss counters per read edge, cleared by flush; eviction counter
  // counts installs into a valid entry holding a different tag.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      evict_cnt_q <= '0;
    end else begin
      if (bus.flush) begin
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
      end else if (bus.read) begin
        if (rd_hit) begin
          hit_cnt_q <= sat_inc(hit_cnt_q);
        end else begin
          miss_cnt_q <= sat_inc(miss_cnt_q);
        end
      end
      if (install && !wr_hit && !free_any) begin
        evict_cnt_q <= sat_inc(evict_cnt_q);
      end
    end
  end

  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;
  assign bus.evict_cnt = evict_cnt_q;
`endif

endmodule
